// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the two-digit timer controller
package timer_pkg;

  // Controller state, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Counting direction as sampled from up_down
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Two display digits give 0..99
  localparam int unsigned DEFAULT_MAX_COUNT = 99;

  // Clamp an 8-bit preset to the count range (unsigned compare)
  function automatic logic [7:0] sat_count(input logic [7:0] val, input logic [7:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to one terminal-count pulse every TICK_DIV enabled cycles
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count is only meaningful while the counter is advancing
  assign tc = enable && (cnt_q == LAST);

  // Next prescaler value: clear wins, disabled holds the partial period
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - run/pause/expire controller and count register for the 0..99 timer
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       preset_load,
  input  logic [7:0] preset_val,
  input  logic       up_down,
  output logic [7:0] count,
  output logic       tick,
  output logic       running,
  output logic       paused,
  output logic       expired
);

  localparam logic [7:0] MAX_C = 8'(MAX_COUNT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       dir_q;
  logic       dir_d;
  logic       tick_q;
  logic       tick_d;

  logic       ps_enable;
  logic       ps_clear;
  logic       ps_tc;
  logic [7:0] stepped;
  logic       hit_zero;

  // The prescaler advances on every RUN cycle, including the edge that pauses,
  // and is held at zero whenever no count is in progress.
  assign ps_enable = (state_q == ST_RUN);
  assign ps_clear  = clear || (state_q == ST_IDLE) || (state_q == ST_EXPIRED);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (ps_enable),
    .clear  (ps_clear),
    .tc     (ps_tc)
  );

  // Count value after one step in the latched direction
  always_comb begin
    stepped  = count_q;
    hit_zero = 1'b0;
    if (dir_q == DIR_UP) begin
      stepped = (count_q >= MAX_C) ? 8'd0 : count_q + 8'd1;
    end else begin
      stepped  = (count_q == 8'd0) ? 8'd0 : count_q - 8'd1;
      hit_zero = (count_q <= 8'd1);
    end
  end

  // Next-state, count and tick decode; clear > start_stop > preset_load
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = 8'd0;
        end else if (start_stop) begin
          // A countdown from zero has nothing to do
          if (!((up_down == DIR_DOWN) && (count_q == 8'd0))) begin
            dir_d   = up_down;
            state_d = ST_RUN;
          end
        end else if (preset_load) begin
          count_d = sat_count(preset_val, MAX_C);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end else begin
          if (ps_tc) begin
            count_d = stepped;
            tick_d  = 1'b1;
            if (hit_zero) begin
              state_d = ST_EXPIRED;
            end
          end
          // Reaching zero on the same edge takes precedence over pausing
          if (start_stop && !(ps_tc && hit_zero)) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        count_d = 8'd0;
        if (clear || start_stop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign running = (state_q == ST_RUN);
  assign paused  = (state_q == ST_PAUSE);
  assign expired = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl with TICK_DIV = 4
module tb_timer_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       preset_load = 1'b0;
  logic [7:0] preset_val = 8'd0;
  logic       up_down = 1'b0;
  logic [7:0] count;
  logic       tick;
  logic       running;
  logic       paused;
  logic       expired;

  timer_ctrl #(
    .TICK_DIV  (TD),
    .MAX_COUNT (99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_stop  (start_stop),
    .clear       (clear),
    .preset_load (preset_load),
    .preset_val  (preset_val),
    .up_down     (up_down),
    .count       (count),
    .tick        (tick),
    .running     (running),
    .paused      (paused),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_load();
    preset_load = 1'b1;
    step(1);
    preset_load = 1'b0;
  endtask

  task automatic expect_tick(input int c, input int y);
    exp_q.push_back('{cnt: c, cyc: y});
  endtask

  task automatic chk_state(input string tag, input int r, input int p, input int e, input int c);
    chk({tag, "_running"}, int'(running), r);
    chk({tag, "_paused"}, int'(paused), p);
    chk({tag, "_expired"}, int'(expired), e);
    chk({tag, "_count"}, int'(count), c);
  endtask

  // Monitor: every tick the DUT presents must match the next scoreboard entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (tick) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: got tick with count %0d at cycle %0d, required no tick", count, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tick_count", int'(count), e.cnt);
        chk("tick_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int s;
    int r;

    // Reset state
    step(2);
    chk_state("reset", 0, 0, 0, 0);
    chk("reset_tick", int'(tick), 0);
    reset = 1'b1;
    step(1);
    chk_state("post_reset", 0, 0, 0, 0);

    // 1: count up, tick every 4 cycles, wrap 99 -> 0 still running
    up_down = 1'b0;
    pulse_ss();
    s = cyc;
    chk_state("t1_start", 1, 0, 0, 0);
    for (int k = 1; k <= 100; k++) expect_tick(k % 100, s + TD * k);
    step(400);
    chk_state("t1_wrap", 1, 0, 0, 0);
    pulse_clr();
    chk_state("t1_clear", 0, 0, 0, 0);

    // 2: preset saturation, countdown to expiry
    preset_val = 8'd200;
    pulse_load();
    chk("t2_preset_sat", int'(count), 99);
    preset_val = 8'd3;
    pulse_load();
    chk("t2_preset_3", int'(count), 3);
    up_down = 1'b1;
    pulse_ss();
    s = cyc;
    expect_tick(2, s + 4);
    expect_tick(1, s + 8);
    expect_tick(0, s + 12);
    step(12);
    chk_state("t2_expired", 0, 0, 1, 0);
    pulse_ss();
    chk_state("t2_ack", 0, 0, 0, 0);

    // 3: pause two cycles after a tick, resume keeps the partial second
    up_down = 1'b0;
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    expect_tick(2, s + 8);
    step(9);
    pulse_ss();
    chk_state("t3_pause", 0, 1, 0, 2);
    step(20);
    chk_state("t3_frozen", 0, 1, 0, 2);
    pulse_ss();
    r = cyc;
    expect_tick(3, r + 2);
    step(2);
    chk_state("t3_resumed", 1, 0, 0, 3);

    // 4a: clear + start_stop on the edge a tick is due
    step(3);
    clear = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    chk_state("t4_clr_ss", 0, 0, 0, 0);
    chk("t4_no_tick", int'(tick), 0);

    // 4b: clear during pause, then a fresh start counts a full period
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    step(5);
    pulse_ss();
    chk_state("t4_pause", 0, 1, 0, 1);
    pulse_clr();
    chk_state("t4_pause_clr", 0, 0, 0, 0);
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    step(4);
    pulse_clr();
    chk_state("t4_idle", 0, 0, 0, 0);

    // 5: countdown from zero ignored; direction and preset ignored while running
    up_down = 1'b1;
    pulse_ss();
    chk_state("t5_ignored", 0, 0, 0, 0);
    step(8);
    up_down = 1'b0;
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    expect_tick(2, s + 8);
    expect_tick(3, s + 12);
    step(1);
    up_down = 1'b1;
    preset_val = 8'd50;
    pulse_load();
    step(10);
    chk_state("t5_dir_held", 1, 0, 0, 3);
    up_down = 1'b0;
    pulse_clr();

    // 6: asynchronous reset mid-run
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    step(6);
    #1 reset = 1'b0;
    #1;
    chk_state("t6_async", 0, 0, 0, 0);
    chk("t6_async_tick", int'(tick), 0);
    step(2);
    #2 reset = 1'b1;
    step(1);
    chk_state("t6_released", 0, 0, 0, 0);
    pulse_ss();
    s = cyc;
    expect_tick(1, s + 4);
    step(3);
    chk("t6_no_early_tick", int'(tick), 0);
    chk("t6_count_early", int'(count), 0);
    step(1);
    chk("t6_first_tick_count", int'(count), 1);

    step(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
